// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable oversampling UART receiver.
// The rx line is synchronized, then sampled three times around the middle of each bit
// and resolved by majority vote. Received words are held in an output register with a
// valid/ready handshake. Parity, framing and overrun errors are reported with the word.
module uart_rx_cfg #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int CLKS_PER_TICK = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W         = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam int TICK_W        = $clog2(OVERSAMPLE);
    localparam int BIT_W         = $clog2(DATA_BITS);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLKS_PER_TICK - 1);
    localparam logic [TICK_W-1:0] TICK_S0   = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_S1   = TICK_W'(OVERSAMPLE / 2);
    localparam logic [TICK_W-1:0] TICK_S2   = TICK_W'(OVERSAMPLE / 2 + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [1:0]        PAR_MODE  = 2'(PARITY);
    localparam logic              STOP_LAST = (STOP_BITS == 2);

    // Reject parameter sets the datapath cannot honour.
    generate
        if ((CLKS_PER_TICK < 2) || (OVERSAMPLE < 8) || ((OVERSAMPLE % 2) != 0) ||
            (DATA_BITS < 5) || (DATA_BITS > 9) || (PARITY < 0) || (PARITY > 2) ||
            ((STOP_BITS != 1) && (STOP_BITS != 2))) begin : g_cfg_check
            $error("uart_rx_cfg: unsupported parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // Majority of three line samples.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic [DIV_W-1:0]     r_div;
    logic                 r_tick;
    state_t               r_state;
    logic                 r_arm;
    logic [TICK_W-1:0]    r_tick_cnt;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic                 r_stop_cnt;
    logic [1:0]           r_samp;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_bit;
    logic                 r_ferr_acc;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_ovr;
    logic                 r_busy;

    logic                 w_decide;
    logic                 w_bit_end;
    logic                 w_bit;
    logic                 w_ones_odd;
    logic                 w_perr;
    logic                 w_ferr;
    logic                 w_can_load;

    assign w_decide   = r_tick && (r_tick_cnt == TICK_S2);
    assign w_bit_end  = r_tick && (r_tick_cnt == TICK_LAST);
    assign w_bit      = maj3(r_samp[0], r_samp[1], r_rx_s);
    assign w_ferr     = r_ferr_acc | ~w_bit;
    assign w_can_load = ~r_valid | rx_ready;

    // Parity verdict for the completed word: odd mode wants an odd total of ones.
    always_comb begin
        w_ones_odd = (^r_shift) ^ r_par_bit;
        case (PAR_MODE)
            2'd1:    w_perr = ~w_ones_odd;
            2'd2:    w_perr = w_ones_odd;
            default: w_perr = 1'b0;
        endcase
    end

    // Two-flop synchronizer; resets to the idle line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Oversample tick divider; held cleared while idle so each frame starts phase-aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else if (r_div == DIV_LAST) begin
            r_div  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_div  <= r_div + DIV_W'(1);
            r_tick <= 1'b0;
        end
    end

    // Frame FSM: bit sampling, shifting, error capture and the output handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_arm      <= 1'b1;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_samp     <= 2'b00;
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
            r_ferr_acc <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_ovr      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            // A completed handshake retires the held word and the overrun report.
            if (r_valid && rx_ready) begin
                r_valid <= 1'b0;
                r_ovr   <= 1'b0;
            end

            // After a framing error, only an idle (high) line re-enables start detection.
            if (!r_arm && r_rx_s) begin
                r_arm <= 1'b1;
            end

            if ((r_state != S_IDLE) && r_tick) begin
                if (r_tick_cnt == TICK_S0) begin
                    r_samp[0] <= r_rx_s;
                end
                if (r_tick_cnt == TICK_S1) begin
                    r_samp[1] <= r_rx_s;
                end
                r_tick_cnt <= (r_tick_cnt == TICK_LAST) ? '0 : r_tick_cnt + TICK_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (r_arm && !r_rx_s) begin
                        r_state    <= S_START;
                        r_tick_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_stop_cnt <= 1'b0;
                        r_ferr_acc <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_decide && w_bit) begin
                        // Start bit did not hold low: treat as a glitch.
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_bit_end) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_decide) begin
                        r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
                    end
                    if (w_bit_end) begin
                        if (r_bit_cnt == BIT_LAST) begin
                            r_bit_cnt <= '0;
                            r_state   <= (PAR_MODE == 2'd0) ? S_STOP : S_PARITY;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (w_decide) begin
                        r_par_bit <= w_bit;
                    end
                    if (w_bit_end) begin
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_decide) begin
                        if (r_stop_cnt == STOP_LAST) begin
                            // Deliver mid stop bit so back-to-back frames are not missed.
                            if (w_can_load) begin
                                r_data  <= r_shift;
                                r_perr  <= w_perr;
                                r_ferr  <= w_ferr;
                                r_valid <= 1'b1;
                            end else begin
                                r_ovr <= 1'b1;
                            end
                            if (w_ferr) begin
                                r_arm <= 1'b0;
                            end
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_ferr_acc <= w_ferr;
                        end
                    end else if (w_bit_end) begin
                        r_stop_cnt <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data     = r_data;
    assign rx_valid    = r_valid;
    assign parity_err  = r_perr;
    assign frame_err   = r_ferr;
    assign overrun_err = r_ovr;
    assign busy        = r_busy;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: scoreboard bench for uart_rx_cfg with an 8N1 and an 8E1 instance.
// Stimulus pushes the expected word into a per-instance queue; monitors pop and compare
// whenever a word is handed over (rx_valid && rx_ready).
`timescale 1ns/1ps
module tb_uart_rx_cfg;

    localparam int CLK_FREQ = 1600000;
    localparam int BAUD     = 10000;
    localparam int OS       = 16;
    localparam int BIT_CLKS = 160;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       ovr;
    } exp_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rx_n  = 1'b1;
    logic       rx_e  = 1'b1;
    logic       rdy_n = 1'b1;
    logic       rdy_e = 1'b1;
    logic [7:0] data_n, data_e;
    logic       val_n, val_e, perr_n, perr_e, ferr_n, ferr_e, ovr_n, ovr_e, busy_n, busy_e;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   vcnt_n  = 0;
    exp_t q_n[$];
    exp_t q_e[$];

    always #5 clk = ~clk;

    uart_rx_cfg #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
        .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) u_dut_n (
        .clk(clk), .reset(reset), .rx(rx_n), .rx_data(data_n), .rx_valid(val_n),
        .rx_ready(rdy_n), .parity_err(perr_n), .frame_err(ferr_n),
        .overrun_err(ovr_n), .busy(busy_n)
    );

    uart_rx_cfg #(
        .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
        .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
    ) u_dut_e (
        .clk(clk), .reset(reset), .rx(rx_e), .rx_data(data_e), .rx_valid(val_e),
        .rx_ready(rdy_e), .parity_err(perr_e), .frame_err(ferr_e),
        .overrun_err(ovr_e), .busy(busy_e)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: what a received frame should report, from the line-level frame contents.
    function automatic exp_t model(input logic [7:0] d, input int par_mode, input logic pbit,
                                   input logic stop, input logic ovr);
        exp_t e;
        int   ones;
        e.data = d;
        ones   = $countones(d) + int'(pbit);
        if (par_mode == 1)      e.perr = ((ones % 2) == 0);
        else if (par_mode == 2) e.perr = ((ones % 2) == 1);
        else                    e.perr = 1'b0;
        e.ferr = ~stop;
        e.ovr  = ovr;
        return e;
    endfunction

    task automatic check_word(input string tag, input exp_t e, input logic [7:0] d,
                              input logic pe, input logic fe, input logic ov);
        check({tag, "_data"},    32'(d),  32'(e.data));
        check({tag, "_parity"},  32'(pe), 32'(e.perr));
        check({tag, "_frame"},   32'(fe), 32'(e.ferr));
        check({tag, "_overrun"}, 32'(ov), 32'(e.ovr));
    endtask

    // Monitor for the 8N1 instance.
    always @(negedge clk) begin
        if (!reset && val_n) begin
            vcnt_n++;
            if (rdy_n) begin
                if (q_n.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL n_unexpected_word: got 0x%0h, expected no word", data_n);
                end else begin
                    check_word("n", q_n.pop_front(), data_n, perr_n, ferr_n, ovr_n);
                end
            end
        end
    end

    // Monitor for the 8E1 instance.
    always @(negedge clk) begin
        if (!reset && val_e && rdy_e) begin
            if (q_e.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL e_unexpected_word: got 0x%0h, expected no word", data_e);
            end else begin
                check_word("e", q_e.pop_front(), data_e, perr_e, ferr_e, ovr_e);
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit which, input logic v);
        if (which) rx_e = v;
        else       rx_n = v;
    endtask

    task automatic send_frame(input bit which, input logic [7:0] d, input bit with_par,
                              input logic pbit, input logic stop);
        drive(which, 1'b0);
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            drive(which, d[i]);
            wait_clks(BIT_CLKS);
        end
        if (with_par) begin
            drive(which, pbit);
            wait_clks(BIT_CLKS);
        end
        drive(which, stop);
        wait_clks(BIT_CLKS);
        drive(which, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_n_data"},  32'(data_n), 32'd0);
        check({tag, "_n_valid"}, 32'(val_n),  32'd0);
        check({tag, "_n_perr"},  32'(perr_n), 32'd0);
        check({tag, "_n_ferr"},  32'(ferr_n), 32'd0);
        check({tag, "_n_ovr"},   32'(ovr_n),  32'd0);
        check({tag, "_n_busy"},  32'(busy_n), 32'd0);
        check({tag, "_e_data"},  32'(data_e), 32'd0);
        check({tag, "_e_valid"}, 32'(val_e),  32'd0);
        check({tag, "_e_perr"},  32'(perr_e), 32'd0);
        check({tag, "_e_ferr"},  32'(ferr_e), 32'd0);
        check({tag, "_e_ovr"},   32'(ovr_e),  32'd0);
        check({tag, "_e_busy"},  32'(busy_e), 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        logic       stop;
        logic       pbit;

        // Reset state
        reset = 1'b1;
        wait_clks(4);
        reset = 1'b0;
        wait_clks(1);
        check_all_zero("reset");

        // 8N1 0xA5: one-cycle valid, busy low once the stop bit has been judged
        vcnt_n = 0;
        q_n.push_back(model(8'hA5, 0, 1'b0, 1'b1, 1'b0));
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
        check("a5_valid_cycles", 32'(vcnt_n), 32'd1);
        check("a5_busy_after_stop", 32'(busy_n), 32'd0);
        wait_clks(BIT_CLKS);

        // 8E1 0x3C with a wrong (set) parity bit
        q_e.push_back(model(8'h3C, 2, 1'b1, 1'b1, 1'b0));
        send_frame(1'b1, 8'h3C, 1'b1, 1'b1, 1'b1);
        wait_clks(BIT_CLKS);

        // Short low pulse is a glitch, then a real frame
        vcnt_n = 0;
        drive(1'b0, 1'b0);
        wait_clks(20);
        check("glitch_busy_during", 32'(busy_n), 32'd1);
        wait_clks(20);
        drive(1'b0, 1'b1);
        wait_clks(2 * BIT_CLKS);
        check("glitch_no_word", 32'(vcnt_n), 32'd0);
        check("glitch_busy_after", 32'(busy_n), 32'd0);
        q_n.push_back(model(8'h81, 0, 1'b0, 1'b1, 1'b0));
        send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
        wait_clks(BIT_CLKS);

        // Break: exactly one 0x00 word with a framing error
        vcnt_n = 0;
        q_n.push_back(model(8'h00, 0, 1'b0, 1'b0, 1'b0));
        drive(1'b0, 1'b0);
        wait_clks(20 * BIT_CLKS);
        check("break_one_word", 32'(vcnt_n), 32'd1);
        check("break_busy_idle", 32'(busy_n), 32'd0);
        drive(1'b0, 1'b1);
        wait_clks(2 * BIT_CLKS);
        check("break_no_more_words", 32'(vcnt_n), 32'd1);

        // Overrun: 0x11 held, 0x22 dropped
        rdy_n = 1'b0;
        q_n.push_back(model(8'h11, 0, 1'b0, 1'b1, 1'b1));
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        wait_clks(BIT_CLKS);
        send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
        wait_clks(BIT_CLKS);
        check("ovr_valid_held", 32'(val_n), 32'd1);
        check("ovr_data_held", 32'(data_n), 32'h11);
        check("ovr_flag_set", 32'(ovr_n), 32'd1);
        rdy_n = 1'b1;
        wait_clks(1);
        check("ovr_valid_cleared", 32'(val_n), 32'd0);
        check("ovr_flag_cleared", 32'(ovr_n), 32'd0);
        wait_clks(BIT_CLKS);

        // Reset mid-frame with a word pending on the 8E1 instance
        rdy_e = 1'b0;
        send_frame(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
        wait_clks(BIT_CLKS);
        check("rst_pre_valid", 32'(val_e), 32'd1);
        d = 8'hC3;
        drive(1'b1, 1'b0);
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, d[i]);
            wait_clks(BIT_CLKS);
        end
        drive(1'b1, d[4]);
        wait_clks(BIT_CLKS / 2);
        check("rst_pre_busy", 32'(busy_e), 32'd1);
        drive(1'b1, 1'b1);
        reset = 1'b1;
        wait_clks(1);
        reset = 1'b0;
        check_all_zero("midrst");
        rdy_e = 1'b1;
        wait_clks(2 * BIT_CLKS);
        q_e.push_back(model(8'h5A, 2, 1'b0, 1'b1, 1'b0));
        send_frame(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);
        wait_clks(BIT_CLKS);

        // Randomized frames on both instances
        for (int k = 0; k < 8; k++) begin
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 5) != 0);
            q_n.push_back(model(d, 0, 1'b0, stop, 1'b0));
            send_frame(1'b0, d, 1'b0, 1'b0, stop);
            wait_clks(BIT_CLKS + int'($urandom_range(0, 60)));

            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 5) != 0);
            pbit = (^d) ^ ($urandom_range(0, 2) == 0);
            q_e.push_back(model(d, 2, pbit, stop, 1'b0));
            send_frame(1'b1, d, 1'b1, pbit, stop);
            wait_clks(BIT_CLKS + int'($urandom_range(0, 60)));
        end

        wait_clks(2 * BIT_CLKS);
        check("n_queue_drained", 32'(q_n.size()), 32'd0);
        check("e_queue_drained", 32'(q_e.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
